uart_rx_fifo: RTL and testbench

- Asynchronous-serial receiver with a small output FIFO; the downstream neighbour of the processor's UART transmitter.
- Consumes an o_UART_Tx-style line (8 data bits, no parity, 1 stop bit, LSB first, idle high).
- Recovers bytes and buffers them for a processor inport or a bench checker.
- Used in-system as the processor's receive path and in benches as a self-checking replacement for behavioural deserialisers.

---
 rtl/uart_rx_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first, idle high) feeding a small first-word-fall-through FIFO.
// Sticky frame-error and overrun flags are cleared by a single-cycle strobe.
module uart_rx_fifo #(
  parameter int unsigned G_CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned G_BAUD        = 115200,
  parameter int unsigned G_FIFO_DEPTH  = 4,   // power of 2, >= 2
  parameter int unsigned G_SYNC_STAGES = 2    // >= 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_UART_Rx,
  output logic [7:0] o_data,
  output logic       o_empty,
  input  logic       i_pop,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clr_err
);

  localparam int unsigned BitCyc = (G_CLK_FREQ_HZ + G_BAUD / 2) / G_BAUD;
  localparam int unsigned CntW   = $clog2(BitCyc);
  localparam int unsigned AddrW  = $clog2(G_FIFO_DEPTH);

  localparam logic [CntW-1:0]  HalfLoad = CntW'((BitCyc - 1) / 2);
  localparam logic [CntW-1:0]  FullLoad = CntW'(BitCyc - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [AddrW-1:0] PtrOne   = AddrW'(1);
  localparam logic [AddrW:0]   CountOne = (AddrW + 1)'(1);
  localparam logic [AddrW:0]   DepthCnt = (AddrW + 1)'(G_FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  // Receiver state
  state_e                   state_q, state_d;
  logic [G_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                     rx_prev_q, rx_prev_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [7:0]               shift_q, shift_d;

  // FIFO state
  logic [7:0]       mem_q [G_FIFO_DEPTH];
  logic [7:0]       mem_d [G_FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             empty_q, empty_d;

  // Sticky flags
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;

  logic rx_s;
  logic fall;
  logic tc;
  logic push;
  logic frame_set;
  logic do_push;
  logic do_pop;
  logic fifo_full;
  logic overrun_set;

  assign rx_s = sync_q[G_SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;
  assign tc   = (cnt_q == '0);

  // Synchroniser shift and previous-sample tracking for start-edge detection
  always_comb begin
    sync_d    = {sync_q[G_SYNC_STAGES-2:0], i_UART_Rx};
    rx_prev_d = rx_s;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (fall) state_d = StStart;
      StStart: if (tc) state_d = rx_s ? StIdle : StData;
      StData:  if (tc && (bit_idx_q == 3'd7)) state_d = StStop;
      // Leave at mid stop bit so a back-to-back start edge is caught.
      StStop:  if (tc) state_d = rx_s ? StIdle : StBreak;
      StBreak: if (rx_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: baud counter, bit index, shift register, push and frame-error events
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (fall) cnt_d = HalfLoad;
      end
      StStart: begin
        if (tc) begin
          cnt_d     = FullLoad;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StData: begin
        if (tc) begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = FullLoad;
          bit_idx_d          = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StStop: begin
        if (tc) begin
          if (rx_s) push = 1'b1;
          else      frame_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: ;
    endcase
  end

  // FIFO pointer/count update; a pop frees a slot for a same-cycle push when full
  always_comb begin
    do_pop      = i_pop && (count_q != '0);
    fifo_full   = (count_q == DepthCnt);
    do_push     = push && (!fifo_full || do_pop);
    overrun_set = push && fifo_full && !do_pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PtrOne;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
  end

  // Sticky error flags; a new event beats a simultaneous clear
  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (i_clr_err) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (frame_set)   frame_err_d = 1'b1;
    if (overrun_set) overrun_d = 1'b1;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      sync_q      <= '1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      for (int i = 0; i < int'(G_FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_data      = mem_q[rd_ptr_q];
  assign o_empty     = empty_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. The line rate is scaled to 32 clocks per bit
// (100 MHz clock, 3.125 Mbaud) so the full scenario list stays short.
`timescale 1ns / 1ps
module tb_uart_rx_fifo;

  localparam int unsigned ClkHz  = 100_000_000;
  localparam int unsigned Baud   = 3_125_000;
  localparam int unsigned Sync   = 2;
  localparam int unsigned Depth  = 4;
  localparam int          BitCyc = 32;
  localparam realtime     BitNs  = 320.0;
  // Sync + 1 + (N-1)/2 + 9N + 1 with N = 32
  localparam int          ExpLat = 307;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic [7:0] data;
  logic       empty;
  logic       pop = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       clr_err = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .G_CLK_FREQ_HZ(ClkHz),
    .G_BAUD       (Baud),
    .G_FIFO_DEPTH (Depth),
    .G_SYNC_STAGES(Sync)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_UART_Rx  (rx_line),
    .o_data     (data),
    .o_empty    (empty),
    .i_pop      (pop),
    .o_frame_err(frame_err),
    .o_overrun  (overrun),
    .i_clr_err  (clr_err)
  );

  // Drive one 8N1 frame; the line is left at the stop-bit value.
  task automatic send_frame(input logic [7:0] b, input realtime bit_ns, input logic stop_v);
    rx_line = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      #(bit_ns);
    end
    rx_line = stop_v;
    #(bit_ns);
  endtask

  task automatic wait_nonempty(input int max_cyc, output int waited);
    waited = 0;
    while (empty && waited < max_cyc) begin
      @(posedge clk);
      #1;
      waited++;
    end
  endtask

  task automatic do_pop();
    @(posedge clk);
    #1 pop = 1'b1;
    @(posedge clk);
    #1 pop = 1'b0;
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got fe=%b ov=%b want 0 0", frame_err, overrun);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_single_byte();
    int lat;
    @(posedge clk);
    #1;
    fork
      send_frame(8'h48, BitNs, 1'b1);
      wait_nonempty(2000, lat);
    join
    checks++;
    if (lat < ExpLat - 3 || lat > ExpLat + 3) begin
      errors++;
      $display("FAIL single_latency got %0d cycles want %0d +-3", lat, ExpLat);
    end
    checks++;
    if (empty !== 1'b0 || data !== 8'h48) begin
      errors++;
      $display("FAIL single_data got empty=%b data=%h want 0 48", empty, data);
    end
    do_pop();
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [14];
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
            8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};
    fork
      begin
        for (int i = 0; i < 14; i++) send_frame(msg[i], BitNs, 1'b1);
      end
      begin
        int w;
        for (int k = 0; k < 14; k++) begin
          wait_nonempty(40 * BitCyc, w);
          checks++;
          if (empty !== 1'b0 || data !== msg[k]) begin
            errors++;
            $display("FAIL b2b_byte%0d got empty=%b data=%h want 0 %h", k, empty, data, msg[k]);
          end
          pop = 1'b1;
          @(posedge clk);
          #1 pop = 1'b0;
        end
      end
    join
    #(2 * BitNs);
    checks++;
    if (overrun !== 1'b0 || frame_err !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_flags got ov=%b fe=%b empty=%b want 0 0 1", overrun, frame_err, empty);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_b;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), BitNs, 1'b1);
    #(BitNs);
    checks++;
    if (overrun !== 1'b1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_flag got ov=%b fe=%b want 1 0", overrun, frame_err);
    end
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i);
      checks++;
      if (empty !== 1'b0 || data !== exp_b) begin
        errors++;
        $display("FAIL ovr_pop%0d got empty=%b data=%h want 0 %h", i, empty, data, exp_b);
      end
      do_pop();
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL ovr_empty got %b want 1", empty); end
    // Pop on empty must be ignored
    do_pop();
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL ovr_pop_empty got %b want 1", empty); end
    do_clr();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_frame_error();
    send_frame(8'hA5, BitNs, 1'b0);
    #(20 * BitNs);
    rx_line = 1'b1;
    #(2 * BitNs);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_flag got %b want 1", frame_err); end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL fe_not_stored got empty=%b want 1", empty); end
    send_frame(8'h3C, BitNs, 1'b1);
    #(BitNs);
    checks++;
    if (empty !== 1'b0 || data !== 8'h3C) begin
      errors++;
      $display("FAIL fe_next_byte got empty=%b data=%h want 0 3c", empty, data);
    end
    do_pop();
  endtask

  task automatic test_glitch_and_reset();
    rx_line = 1'b0;
    #100;
    rx_line = 1'b1;
    #(3 * BitNs);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL glitch_no_byte got empty=%b want 1", empty); end
    send_frame(8'h5A, BitNs, 1'b1);
    #(BitNs);
    checks++;
    if (empty !== 1'b0 || data !== 8'h5A) begin
      errors++;
      $display("FAIL glitch_next_byte got empty=%b data=%h want 0 5a", empty, data);
    end
    // 0x5A stays queued and frame_err is still set, so reset has something to clear.
    fork
      send_frame(8'h55, BitNs, 1'b1);
      begin
        #(5.5 * BitNs);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (empty !== 1'b1 || data !== 8'h00) begin
          errors++;
          $display("FAIL rst_mid_fifo got empty=%b data=%h want 1 00", empty, data);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_flags got fe=%b ov=%b want 0 0", frame_err, overrun);
        end
        rst_n = 1'b1;
      end
    join
    // The tail of the aborted frame may look like a new frame; flush it.
    #(12 * BitNs);
    for (int i = 0; i < 8; i++) if (!empty) do_pop();
    do_clr();
    send_frame(8'hAA, BitNs, 1'b1);
    #(BitNs);
    checks++;
    if (empty !== 1'b0 || data !== 8'hAA || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_byte got empty=%b data=%h fe=%b want 0 aa 0", empty, data, frame_err);
    end
    do_pop();
  endtask

  task automatic test_baud_skew();
    realtime bits [2];
    bits[0] = BitNs / 1.02;
    bits[1] = BitNs / 0.98;
    for (int i = 0; i < 2; i++) begin
      send_frame(8'h96, bits[i], 1'b1);
      #(BitNs);
      checks++;
      if (empty !== 1'b0 || data !== 8'h96 || frame_err !== 1'b0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL skew%0d got empty=%b data=%h fe=%b ov=%b want 0 96 0 0",
                 i, empty, data, frame_err, overrun);
      end
      do_pop();
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL skew%0d_pop got empty=%b want 1", i, empty); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_glitch_and_reset();
    test_baud_skew();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
